// File: rtl/rotate_pkg.sv
// Shared types and helpers for the tiled image-rotation address generator.
package rotate_pkg;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

    localparam logic [1:0] DEG_0   = 2'd0;
    localparam logic [1:0] DEG_90  = 2'd1;
    localparam logic [1:0] DEG_180 = 2'd2;
    localparam logic [1:0] DEG_270 = 2'd3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Counter-clockwise turns are folded into the equivalent clockwise count.
    function automatic logic [1:0] eff_turns(input logic direction, input logic [1:0] degrees);
        logic [1:0] turns;
        turns = degrees;
        if (!direction) begin
            unique case (degrees)
                DEG_0:   turns = DEG_0;
                DEG_90:  turns = DEG_270;
                DEG_180: turns = DEG_180;
                DEG_270: turns = DEG_90;
            endcase
        end
        return turns;
    endfunction

endpackage

// File: rtl/rotate_tile_map.sv
// Maps a source tile coordinate to its rotated destination tile coordinate.
module rotate_tile_map
    import rotate_pkg::*;
#(
    parameter int unsigned DIM_W = 16
) (
    input  logic [1:0]       i_k,
    input  logic [DIM_W-1:0] i_tr,
    input  logic [DIM_W-1:0] i_tc,
    input  logic [DIM_W-1:0] i_tr_n,
    input  logic [DIM_W-1:0] i_tc_n,
    output logic [DIM_W-1:0] o_dtr,
    output logic [DIM_W-1:0] o_dtc,
    output logic             o_wo_sel
);

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    always_comb begin
        o_dtr = i_tr;
        o_dtc = i_tc;
        unique case (i_k)
            DEG_0: begin
                o_dtr = i_tr;
                o_dtc = i_tc;
            end
            DEG_90: begin
                o_dtr = i_tc;
                o_dtc = i_tr_n - i_tr - ONE;
            end
            DEG_180: begin
                o_dtr = i_tr_n - i_tr - ONE;
                o_dtc = i_tc_n - i_tc - ONE;
            end
            DEG_270: begin
                o_dtr = i_tc_n - i_tc - ONE;
                o_dtc = i_tr;
            end
        endcase
    end

    // Odd quarter turns swap the image axes, so the output width is the padded height.
    assign o_wo_sel = i_k[0];

endmodule

// File: rtl/rotate_tile_addr_gen.sv
// Tile-walking burst address generator: TILE read bursts per source tile, then TILE
// write bursts to the rotated destination tile.
module rotate_tile_addr_gen
    import rotate_pkg::*;
#(
    parameter int unsigned TILE   = 8,
    parameter int unsigned BPP    = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 16
) (
    input  logic                   I_HCLK,
    input  logic                   I_HRESET,
    input  logic                   I_START,
    input  logic [DIM_W-1:0]       I_HEIGHT,
    input  logic [DIM_W-1:0]       I_WIDTH,
    input  logic                   I_DIRECTION,
    input  logic [1:0]             I_DEGREES,
    input  logic [ADDR_W-1:0]      I_SRC_BASE,
    input  logic [ADDR_W-1:0]      I_DST_BASE,
    input  logic                   I_DMA_READY,
    output logic [ADDR_W-1:0]      O_ADDR,
    output logic                   O_VALID,
    output logic                   O_WRITE,
    output logic [clog2(TILE)-1:0] O_ROW,
    output logic [clog2(TILE)-1:0] O_BEAT,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_ERR
);

    localparam int unsigned        TW     = clog2(TILE);
    localparam logic [TW-1:0]      LAST   = TW'(TILE - 1);
    localparam logic [ADDR_W-1:0]  TILE_A = ADDR_W'(TILE);
    localparam logic [ADDR_W-1:0]  TBPP_A = ADDR_W'(TILE * BPP);
    localparam logic [DIM_W:0]     RND    = (DIM_W + 1)'(TILE - 1);
    localparam logic [DIM_W-1:0]   ONE    = DIM_W'(1);
    localparam logic [DIM_W-1:0]   ZERO   = '0;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_k, w_k_nxt;
    logic [DIM_W-1:0]    r_tr_n, w_tr_n_nxt, r_tc_n, w_tc_n_nxt;
    logic [DIM_W-1:0]    r_tr, w_tr_nxt, r_tc, w_tc_nxt;
    logic [ADDR_W-1:0]   r_ss, w_ss_nxt, r_ds, w_ds_nxt;
    logic [ADDR_W-1:0]   r_src, w_src_nxt, r_dst, w_dst_nxt;
    logic [ADDR_W-1:0]   r_wr_base, w_wr_base_nxt, r_addr, w_addr_nxt;
    logic [TW-1:0]       r_row, w_row_nxt, r_beat, w_beat_nxt;
    logic                r_valid, w_valid_nxt, r_write, w_write_nxt;
    logic                r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;

    logic                w_idle, w_accept, w_last_tc, w_last_tile, w_wo_sel;
    logic [DIM_W:0]      w_h_ext, w_w_ext;
    logic [DIM_W-1:0]    w_in_tr_n, w_in_tc_n, w_ntr, w_ntc, w_dtr, w_dtc;
    logic [DIM_W-1:0]    w_cfg_tr_n, w_cfg_tc_n;
    logic [1:0]          w_in_k, w_cfg_k;
    logic [ADDR_W-1:0]   w_in_ss, w_in_ds, w_cfg_ss, w_cfg_ds, w_cfg_src, w_cfg_dst;
    logic [ADDR_W-1:0]   w_rd_base, w_wr_base, w_stride;

    // Geometry from the raw inputs, used only on the start cycle.
    assign w_h_ext   = {1'b0, I_HEIGHT} + RND;
    assign w_w_ext   = {1'b0, I_WIDTH} + RND;
    assign w_in_tr_n = DIM_W'(w_h_ext >> TW);
    assign w_in_tc_n = DIM_W'(w_w_ext >> TW);
    assign w_in_k    = eff_turns(I_DIRECTION, I_DEGREES);
    assign w_in_ss   = ADDR_W'(w_in_tc_n) * TBPP_A;
    assign w_in_ds   = ADDR_W'(w_wo_sel ? w_cfg_tr_n : w_cfg_tc_n) * TBPP_A;

    assign w_idle     = (r_state == StIdle);
    assign w_cfg_k    = w_idle ? w_in_k     : r_k;
    assign w_cfg_tr_n = w_idle ? w_in_tr_n  : r_tr_n;
    assign w_cfg_tc_n = w_idle ? w_in_tc_n  : r_tc_n;
    assign w_cfg_ss   = w_idle ? w_in_ss    : r_ss;
    assign w_cfg_ds   = w_idle ? w_in_ds    : r_ds;
    assign w_cfg_src  = w_idle ? I_SRC_BASE : r_src;
    assign w_cfg_dst  = w_idle ? I_DST_BASE : r_dst;

    assign w_last_tc   = (r_tc == r_tc_n - ONE);
    assign w_last_tile = w_last_tc && (r_tr == r_tr_n - ONE);
    assign w_ntr       = w_idle ? ZERO : (w_last_tc ? r_tr + ONE : r_tr);
    assign w_ntc       = (w_idle || w_last_tc) ? ZERO : r_tc + ONE;

    rotate_tile_map #(
        .DIM_W (DIM_W)
    ) u_map (
        .i_k      (w_cfg_k),
        .i_tr     (w_ntr),
        .i_tc     (w_ntc),
        .i_tr_n   (w_cfg_tr_n),
        .i_tc_n   (w_cfg_tc_n),
        .o_dtr    (w_dtr),
        .o_dtc    (w_dtc),
        .o_wo_sel (w_wo_sel)
    );

    // Tile base addresses need multipliers, evaluated only at start or tile change.
    assign w_rd_base = w_cfg_src + ADDR_W'(w_ntr) * w_cfg_ss * TILE_A + ADDR_W'(w_ntc) * TBPP_A;
    assign w_wr_base = w_cfg_dst + ADDR_W'(w_dtr) * w_cfg_ds * TILE_A + ADDR_W'(w_dtc) * TBPP_A;
    assign w_accept  = r_valid & I_DMA_READY;
    assign w_stride  = r_write ? r_ds : r_ss;

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_tr_n_nxt    = r_tr_n;
        w_tc_n_nxt    = r_tc_n;
        w_tr_nxt      = r_tr;
        w_tc_nxt      = r_tc;
        w_ss_nxt      = r_ss;
        w_ds_nxt      = r_ds;
        w_src_nxt     = r_src;
        w_dst_nxt     = r_dst;
        w_wr_base_nxt = r_wr_base;
        w_addr_nxt    = r_addr;
        w_row_nxt     = r_row;
        w_beat_nxt    = r_beat;
        w_valid_nxt   = r_valid;
        w_write_nxt   = r_write;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (I_START) begin
                    if (I_HEIGHT == ZERO || I_WIDTH == ZERO) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = StRead;
                        w_k_nxt       = w_in_k;
                        w_tr_n_nxt    = w_in_tr_n;
                        w_tc_n_nxt    = w_in_tc_n;
                        w_ss_nxt      = w_in_ss;
                        w_ds_nxt      = w_in_ds;
                        w_src_nxt     = I_SRC_BASE;
                        w_dst_nxt     = I_DST_BASE;
                        w_tr_nxt      = ZERO;
                        w_tc_nxt      = ZERO;
                        w_addr_nxt    = w_rd_base;
                        w_wr_base_nxt = w_wr_base;
                        w_row_nxt     = '0;
                        w_beat_nxt    = '0;
                        w_valid_nxt   = 1'b1;
                        w_write_nxt   = 1'b0;
                        w_busy_nxt    = 1'b1;
                    end
                end
            end
            StRead, StWrite: begin
                if (w_accept) begin
                    if (r_beat != LAST) begin
                        w_beat_nxt = r_beat + 1'b1;
                    end else begin
                        w_beat_nxt = '0;
                        if (r_row != LAST) begin
                            w_row_nxt  = r_row + 1'b1;
                            w_addr_nxt = r_addr + w_stride;
                        end else begin
                            w_row_nxt = '0;
                            if (r_state == StRead) begin
                                w_state_nxt = StWrite;
                                w_write_nxt = 1'b1;
                                w_addr_nxt  = r_wr_base;
                            end else if (w_last_tile) begin
                                w_state_nxt = StDone;
                                w_valid_nxt = 1'b0;
                                w_write_nxt = 1'b0;
                                w_addr_nxt  = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt   = StRead;
                                w_write_nxt   = 1'b0;
                                w_tr_nxt      = w_ntr;
                                w_tc_nxt      = w_ntc;
                                w_addr_nxt    = w_rd_base;
                                w_wr_base_nxt = w_wr_base;
                            end
                        end
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_state   <= StIdle;
            r_k       <= '0;
            r_tr_n    <= '0;
            r_tc_n    <= '0;
            r_tr      <= '0;
            r_tc      <= '0;
            r_ss      <= '0;
            r_ds      <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_wr_base <= '0;
            r_addr    <= '0;
            r_row     <= '0;
            r_beat    <= '0;
            r_valid   <= 1'b0;
            r_write   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_tr_n    <= w_tr_n_nxt;
            r_tc_n    <= w_tc_n_nxt;
            r_tr      <= w_tr_nxt;
            r_tc      <= w_tc_nxt;
            r_ss      <= w_ss_nxt;
            r_ds      <= w_ds_nxt;
            r_src     <= w_src_nxt;
            r_dst     <= w_dst_nxt;
            r_wr_base <= w_wr_base_nxt;
            r_addr    <= w_addr_nxt;
            r_row     <= w_row_nxt;
            r_beat    <= w_beat_nxt;
            r_valid   <= w_valid_nxt;
            r_write   <= w_write_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign O_ADDR  = r_addr;
    assign O_VALID = r_valid;
    assign O_WRITE = r_write;
    assign O_ROW   = r_row;
    assign O_BEAT  = r_beat;
    assign O_BUSY  = r_busy;
    assign O_DONE  = r_done;
    assign O_ERR   = r_err;

endmodule

// File: tb/tb_rotate_tile_addr_gen.sv
// Directed bench for rotate_tile_addr_gen with hand-computed burst addresses.
module tb_rotate_tile_addr_gen;

    logic        clk = 1'b0;
    logic        rst, start, dir, ready;
    logic [15:0] height, width;
    logic [1:0]  deg;
    logic [31:0] src, dst;
    logic [31:0] addr;
    logic        valid, wr, busy, done, err;
    logic [2:0]  row, beat;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int nmis;

    logic [31:0] log_addr[$];
    logic [31:0] save_addr[$];
    logic [2:0]  log_row[$];
    logic [2:0]  save_row[$];
    logic        log_wr[$];
    logic        save_wr[$];

    always #5 clk = ~clk;

    rotate_tile_addr_gen dut (
        .I_HCLK      (clk),
        .I_HRESET    (rst),
        .I_START     (start),
        .I_HEIGHT    (height),
        .I_WIDTH     (width),
        .I_DIRECTION (dir),
        .I_DEGREES   (deg),
        .I_SRC_BASE  (src),
        .I_DST_BASE  (dst),
        .I_DMA_READY (ready),
        .O_ADDR      (addr),
        .O_VALID     (valid),
        .O_WRITE     (wr),
        .O_ROW       (row),
        .O_BEAT      (beat),
        .O_BUSY      (busy),
        .O_DONE      (done),
        .O_ERR       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] h, input logic [15:0] w, input logic d,
                            input logic [1:0] g);
        height = h;
        width  = w;
        dir    = d;
        deg    = g;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Logs the start of every burst until O_DONE; optional 3-cycle stall at read row 2 beat 4.
    task automatic run_op(input bit stall, output int cycles);
        bit stalled;
        stalled = 1'b0;
        cycles  = 0;
        log_addr.delete();
        log_row.delete();
        log_wr.delete();
        while (!done && cycles < 5000) begin
            if (stall && !stalled && valid && !wr && row == 3'd2 && beat == 3'd4) begin
                stalled = 1'b1;
                ready   = 1'b0;
                repeat (3) begin
                    tick();
                    cycles++;
                    check("stall_addr", addr, 32'h1090);
                    check("stall_row", 32'(row), 32'd2);
                    check("stall_beat", 32'(beat), 32'd4);
                end
                ready = 1'b1;
            end
            if (valid && ready && beat == 3'd0) begin
                log_addr.push_back(addr);
                log_row.push_back(row);
                log_wr.push_back(wr);
            end
            tick();
            cycles++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic save_logs();
        save_addr = log_addr;
        save_row  = log_row;
        save_wr   = log_wr;
    endtask

    task automatic compare_logs(input string tag);
        nmis = 0;
        for (int i = 0; i < save_addr.size(); i++) begin
            if (i >= log_addr.size() || log_addr[i] !== save_addr[i] ||
                log_row[i] !== save_row[i] || log_wr[i] !== save_wr[i]) nmis++;
        end
        check({tag, "_len"}, 32'(log_addr.size()), 32'(save_addr.size()));
        check({tag, "_mis"}, 32'(nmis), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; height = '0; width = '0; dir = 1'b1; deg = 2'd0;
        src = 32'h1000; dst = 32'h8000; ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // 8x8, no rotation
        do_start(16'd8, 16'd8, 1'b1, 2'd0);
        check("t1_first_valid", 32'(valid), 32'd1);
        check("t1_first_addr", addr, 32'h1000);
        check("t1_first_busy", 32'(busy), 32'd1);
        check("t1_first_wr", 32'(wr), 32'd0);
        run_op(1'b0, cyc);
        check("t1_cycles", 32'(cyc), 32'd128);
        check("t1_bursts", 32'(log_addr.size()), 32'd16);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t1_rd%0d", j), log_addr[j], 32'h1000 + 32'(j * 24));
            check($sformatf("t1_wr%0d", j), log_addr[8 + j], 32'h8000 + 32'(j * 24));
            check($sformatf("t1_wflag%0d", j), 32'(log_wr[8 + j]), 32'd1);
        end
        check("t1_done_busy", 32'(busy), 32'd1);
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_valid", 32'(valid), 32'd0);

        // zero width is rejected
        do_start(16'd8, 16'd0, 1'b1, 2'd0);
        check("err_pulse", 32'(err), 32'd1);
        check("err_valid", 32'(valid), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        tick();
        check("err_clear", 32'(err), 32'd0);
        check("err_valid2", 32'(valid), 32'd0);

        // 16x24, 90 clockwise: TR=2, TC=3, DS=48
        do_start(16'd16, 16'd24, 1'b1, 2'd1);
        run_op(1'b0, cyc);
        check("t2_cycles", 32'(cyc), 32'd768);
        check("t2_bursts", 32'(log_addr.size()), 32'd96);
        check("t2_t00_wr", log_addr[8], 32'h8018);
        check("t2_t00_wflag", 32'(log_wr[8]), 32'd1);
        check("t2_t12_wr0", log_addr[88], 32'h8300);
        check("t2_t12_wr1", log_addr[89], 32'h8330);
        check("t2_t12_row1", 32'(log_row[89]), 32'd1);
        save_logs();
        tick();

        // same job with a 3-cycle READY stall
        do_start(16'd16, 16'd24, 1'b1, 2'd1);
        run_op(1'b1, cyc);
        check("stall_cycles", 32'(cyc), 32'd771);
        compare_logs("stall_stream");
        tick();

        // 90 ccw equals 270 cw
        do_start(16'd16, 16'd24, 1'b0, 2'd1);
        run_op(1'b0, cyc);
        check("k3_t00_wr", log_addr[8], 32'h8300);
        save_logs();
        tick();
        do_start(16'd16, 16'd24, 1'b1, 2'd3);
        run_op(1'b0, cyc);
        compare_logs("k3_stream");
        tick();

        // 10x5 at 180: padded to 16x8, SS=DS=24
        do_start(16'd10, 16'd5, 1'b1, 2'd2);
        run_op(1'b0, cyc);
        check("t3_cycles", 32'(cyc), 32'd256);
        check("t3_rd_first", log_addr[0], 32'h1000);
        check("t3_rd_last", log_addr[7], 32'h10A8);
        check("t3_wr_first", log_addr[8], 32'h80C0);
        check("t3_t10_rd", log_addr[16], 32'h10C0);
        check("t3_t10_wr", log_addr[24], 32'h8000);
        tick();

        // start during WRITE is ignored
        do_start(16'd8, 16'd8, 1'b1, 2'd0);
        repeat (64) tick();
        check("sw_pre_wr", 32'(wr), 32'd1);
        check("sw_pre_addr", addr, 32'h8000);
        height = 16'd16; width = 16'd24; src = 32'h4000; start = 1'b1;
        tick();
        start = 1'b0;
        check("sw_addr", addr, 32'h8000);
        check("sw_beat", 32'(beat), 32'd1);
        check("sw_wr", 32'(wr), 32'd1);
        run_op(1'b0, cyc);
        check("sw_cycles", 32'(cyc), 32'd63);
        tick();
        check("sw_idle_valid", 32'(valid), 32'd0);
        check("sw_idle_busy", 32'(busy), 32'd0);
        src = 32'h1000;

        // reset mid-WRITE, then restart from tile (0,0)
        do_start(16'd16, 16'd24, 1'b1, 2'd1);
        repeat (70) tick();
        check("mr_pre_wr", 32'(wr), 32'd1);
        rst = 1'b1;
        tick();
        check("mr_valid", 32'(valid), 32'd0);
        check("mr_addr", addr, 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_wr", 32'(wr), 32'd0);
        check("mr_beat", 32'(beat), 32'd0);
        check("mr_row", 32'(row), 32'd0);
        rst = 1'b0;
        tick();
        check("mr_idle_valid", 32'(valid), 32'd0);
        do_start(16'd16, 16'd24, 1'b1, 2'd1);
        check("mr_restart_addr", addr, 32'h1000);
        check("mr_restart_row", 32'(row), 32'd0);
        repeat (64) tick();
        check("mr_restart_wr", addr, 32'h8018);
        check("mr_restart_wflag", 32'(wr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
